skin_bbox: RTL and testbench

SKIN_BBOX -- requirements
Module: skin_bbox

---
 rtl/skin_bbox.sv | 192 +++++++++++++++++++
 tb/tb_skin_bbox.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/skin_bbox.sv
// Skin-mask bounding-box tracker: accumulates min/max column/row and pixel count of
// skin pixels over each complete frame and reports them once per frame.
module skin_bbox #(
    parameter int unsigned XW      = 12,
    parameter int unsigned YW      = 12,
    parameter int unsigned CW      = 24,
    parameter int unsigned MIN_PIX = 64
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic [7:0]    iY,
    input  logic          iLineValid,
    input  logic          iFrameValid,
    output logic [XW-1:0] oXMin,
    output logic [XW-1:0] oXMax,
    output logic [YW-1:0] oYMin,
    output logic [YW-1:0] oYMax,
    output logic [CW-1:0] oCount,
    output logic          oDetected,
    output logic          oValid
);

    typedef enum logic [1:0] {StSync, StArmed, StActive, StReport} state_e;

    localparam logic [XW-1:0] XAll = '1;
    localparam logic [YW-1:0] YAll = '1;
    localparam logic [CW-1:0] CAll = '1;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          lv_q, lv_d;

    logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [XW-1:0] rxmin_q, rxmin_d, rxmax_q, rxmax_d;
    logic [YW-1:0] rymin_q, rymin_d, rymax_q, rymax_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          rdet_q, rdet_d;
    logic          valid_q, valid_d;

    logic          active, skin, det_ok;
    logic [XW-1:0] bxmin, bxmax, uxmin, uxmax;
    logic [YW-1:0] bymin, bymax, uymin, uymax;
    logic [CW-1:0] bcnt, ucnt;

    always_comb begin
        active = iFrameValid & iLineValid;
        skin   = active & iY[7];
        det_ok = (cnt_q >= CW'(MIN_PIX)) && (cnt_q != '0);

        x_d = x_q;
        if (!iLineValid) begin
            x_d = '0;
        end else if (active && x_q != XAll) begin
            x_d = x_q + XW'(1);
        end

        y_d = y_q;
        if (!iFrameValid) begin
            y_d = '0;
        end else if (lv_q && !iLineValid && y_q != YAll) begin
            y_d = y_q + YW'(1);
        end
        lv_d = iLineValid;

        // The first cycle of a frame is seen in StArmed, so its pixel folds into cleared values.
        bxmin = xmin_q;
        bxmax = xmax_q;
        bymin = ymin_q;
        bymax = ymax_q;
        bcnt  = cnt_q;
        if (state_q == StArmed) begin
            bxmin = XAll;
            bxmax = '0;
            bymin = YAll;
            bymax = '0;
            bcnt  = '0;
        end

        uxmin = bxmin;
        uxmax = bxmax;
        uymin = bymin;
        uymax = bymax;
        ucnt  = bcnt;
        if (skin) begin
            if (x_q < bxmin) uxmin = x_q;
            if (x_q > bxmax) uxmax = x_q;
            if (y_q < bymin) uymin = y_q;
            if (y_q > bymax) uymax = y_q;
            if (bcnt != CAll) ucnt = bcnt + CW'(1);
        end

        state_d = state_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        cnt_d   = cnt_q;
        rxmin_d = rxmin_q;
        rxmax_d = rxmax_q;
        rymin_d = rymin_q;
        rymax_d = rymax_q;
        rcnt_d  = rcnt_q;
        rdet_d  = rdet_q;
        valid_d = 1'b0;

        unique case (state_q)
            StSync: begin
                if (!iFrameValid) state_d = StArmed;
            end
            StArmed: begin
                xmin_d = uxmin;
                xmax_d = uxmax;
                ymin_d = uymin;
                ymax_d = uymax;
                cnt_d  = ucnt;
                if (iFrameValid) state_d = StActive;
            end
            StActive: begin
                xmin_d = uxmin;
                xmax_d = uxmax;
                ymin_d = uymin;
                ymax_d = uymax;
                cnt_d  = ucnt;
                if (!iFrameValid) begin
                    state_d = StReport;
                    valid_d = 1'b1;
                    rcnt_d  = cnt_q;
                    rdet_d  = det_ok;
                    rxmin_d = det_ok ? xmin_q : '0;
                    rxmax_d = det_ok ? xmax_q : '0;
                    rymin_d = det_ok ? ymin_q : '0;
                    rymax_d = det_ok ? ymax_q : '0;
                end
            end
            StReport: begin
                state_d = StArmed;
            end
            default: state_d = StSync;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= StSync;
            x_q     <= '0;
            y_q     <= '0;
            lv_q    <= 1'b0;
            xmin_q  <= XAll;
            xmax_q  <= '0;
            ymin_q  <= YAll;
            ymax_q  <= '0;
            cnt_q   <= '0;
            rxmin_q <= '0;
            rxmax_q <= '0;
            rymin_q <= '0;
            rymax_q <= '0;
            rcnt_q  <= '0;
            rdet_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lv_q    <= lv_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            cnt_q   <= cnt_d;
            rxmin_q <= rxmin_d;
            rxmax_q <= rxmax_d;
            rymin_q <= rymin_d;
            rymax_q <= rymax_d;
            rcnt_q  <= rcnt_d;
            rdet_q  <= rdet_d;
            valid_q <= valid_d;
        end
    end

    assign oXMin     = rxmin_q;
    assign oXMax     = rxmax_q;
    assign oYMin     = rymin_q;
    assign oYMax     = rymax_q;
    assign oCount    = rcnt_q;
    assign oDetected = rdet_q;
    assign oValid    = valid_q;

endmodule

// File: tb/tb_skin_bbox.sv
// Self-checking bench for skin_bbox: a wide-column and a 3-bit-column instance share stimulus
// and are compared against a per-frame skin-map reference model.
module tb_skin_bbox;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [7:0]  iY;
    logic        iLineValid;
    logic        iFrameValid;

    logic [11:0] a_xmin, a_xmax, a_ymin, a_ymax;
    logic [23:0] a_count;
    logic        a_det, a_valid;
    logic [2:0]  b_xmin, b_xmax;
    logic [11:0] b_ymin, b_ymax;
    logic [23:0] b_count;
    logic        b_det, b_valid;

    int n_cmp = 0;
    int n_err = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    bit skin_map [0:7][0:11];

    always #5 iClk = ~iClk;

    skin_bbox #(.XW(12), .YW(12), .CW(24), .MIN_PIX(2)) u_dut_a (
        .iClk(iClk), .iRst(iRst), .iY(iY), .iLineValid(iLineValid),
        .iFrameValid(iFrameValid), .oXMin(a_xmin), .oXMax(a_xmax), .oYMin(a_ymin),
        .oYMax(a_ymax), .oCount(a_count), .oDetected(a_det), .oValid(a_valid)
    );

    skin_bbox #(.XW(3), .YW(12), .CW(24), .MIN_PIX(2)) u_dut_b (
        .iClk(iClk), .iRst(iRst), .iY(iY), .iLineValid(iLineValid),
        .iFrameValid(iFrameValid), .oXMin(b_xmin), .oXMax(b_xmax), .oYMin(b_ymin),
        .oYMax(b_ymax), .oCount(b_count), .oDetected(b_det), .oValid(b_valid)
    );

    always @(negedge iClk) begin
        if (a_valid) pulses_a <= pulses_a + 1;
        if (b_valid) pulses_b <= pulses_b + 1;
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_map();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 12; c++)
                skin_map[r][c] = 1'b0;
    endtask

    // Reference: bbox/count of the skin map over a w x h frame, columns clamped to 2^xw-1.
    task automatic model(input int xw, input int w, input int h, output int cnt,
                         output int xmin, output int xmax, output int ymin, output int ymax,
                         output int det);
        int xs;
        int xcap;
        xcap = (1 << xw) - 1;
        cnt = 0; xmin = 1 << 30; xmax = 0; ymin = 1 << 30; ymax = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (skin_map[r][c]) begin
                    xs = (c > xcap) ? xcap : c;
                    cnt++;
                    if (xs < xmin) xmin = xs;
                    if (xs > xmax) xmax = xs;
                    if (r < ymin) ymin = r;
                    if (r > ymax) ymax = r;
                end
            end
        end
        det = (cnt >= 2) ? 1 : 0;
        if (det == 0) begin
            xmin = 0; xmax = 0; ymin = 0; ymax = 0;
        end
    endtask

    task automatic check_results(input string tag);
        int cnt, xmin, xmax, ymin, ymax, det;
        model(12, 12, 8, cnt, xmin, xmax, ymin, ymax, det);
        chk({tag, ".a_count"}, a_count, cnt);
        chk({tag, ".a_det"}, a_det, det);
        chk({tag, ".a_xmin"}, a_xmin, xmin);
        chk({tag, ".a_xmax"}, a_xmax, xmax);
        chk({tag, ".a_ymin"}, a_ymin, ymin);
        chk({tag, ".a_ymax"}, a_ymax, ymax);
        model(3, 12, 8, cnt, xmin, xmax, ymin, ymax, det);
        chk({tag, ".b_count"}, b_count, cnt);
        chk({tag, ".b_det"}, b_det, det);
        chk({tag, ".b_xmin"}, b_xmin, xmin);
        chk({tag, ".b_xmax"}, b_xmax, xmax);
        chk({tag, ".b_ymin"}, b_ymin, ymin);
        chk({tag, ".b_ymax"}, b_ymax, ymax);
    endtask

    // Map entries outside w x h must be clear; rst_row >= 0 pulses iRst before that row.
    task automatic send_frame(input string tag, input int w, input int h, input int rst_row);
        int pa0, pb0, rep;
        rep = (rst_row < 0) ? 1 : 0;
        pa0 = pulses_a;
        pb0 = pulses_b;
        iFrameValid = 1'b1; iLineValid = 1'b0; iY = 8'd0;
        tick();
        for (int r = 0; r < h; r++) begin
            if (r == rst_row) begin
                iRst = 1'b1;
                tick();
                chk({tag, ".rst_valid"}, a_valid, 0);
                chk({tag, ".rst_count"}, a_count, 0);
                chk({tag, ".rst_xmax"}, b_xmax, 0);
                tick();
                iRst = 1'b0;
            end
            iLineValid = 1'b1;
            for (int c = 0; c < w; c++) begin
                iY = skin_map[r][c] ? 8'd255 : 8'd0;
                tick();
            end
            iLineValid = 1'b0; iY = 8'd0;
            repeat ($urandom_range(1, 3)) tick();
        end
        chk({tag, ".pre_valid"}, a_valid, 0);
        iFrameValid = 1'b0;
        tick();
        chk({tag, ".valid_a"}, a_valid, rep);
        chk({tag, ".valid_b"}, b_valid, rep);
        if (rep != 0) check_results(tag);
        tick();
        chk({tag, ".valid_drop"}, a_valid, 0);
        // Skin pixels on lines outside the frame must be ignored.
        repeat (3) begin
            iLineValid = 1'b1; iY = 8'd255;
            tick();
        end
        iLineValid = 1'b0; iY = 8'd0;
        tick();
        tick();
        chk({tag, ".pulses_a"}, pulses_a - pa0, rep);
        chk({tag, ".pulses_b"}, pulses_b - pb0, rep);
        if (rep != 0) check_results({tag, ".hold"});
    endtask

    initial begin
        iRst = 1'b1; iY = 8'd0; iLineValid = 1'b0; iFrameValid = 1'b0;
        tick();
        tick();
        chk("reset.valid", a_valid, 0);
        chk("reset.det", a_det, 0);
        chk("reset.count", a_count, 0);
        chk("reset.xmin", a_xmin, 0);
        chk("reset.ymax", b_ymax, 0);
        iRst = 1'b0;
        tick();
        tick();

        clear_map();
        skin_map[1][2] = 1'b1; skin_map[1][5] = 1'b1; skin_map[2][3] = 1'b1;
        send_frame("f3pix", 8, 4, -1);

        clear_map();
        skin_map[3][4] = 1'b1;
        send_frame("f1pix", 8, 4, -1);

        clear_map();
        send_frame("fempty", 8, 4, -1);

        clear_map();
        skin_map[0][1] = 1'b1; skin_map[0][9] = 1'b1;
        send_frame("fxsat", 10, 1, -1);

        clear_map();
        skin_map[0][0] = 1'b1; skin_map[3][6] = 1'b1;
        send_frame("frst_mid", 8, 4, 2);
        clear_map();
        skin_map[0][7] = 1'b1; skin_map[2][1] = 1'b1;
        send_frame("fpost1", 8, 4, -1);
        clear_map();
        skin_map[1][3] = 1'b1; skin_map[3][3] = 1'b1; skin_map[3][4] = 1'b1;
        send_frame("fpost2", 8, 4, -1);

        clear_map();
        skin_map[1][1] = 1'b1; skin_map[2][2] = 1'b1;
        send_frame("frst_fv", 8, 4, 0);
        send_frame("fafter", 8, 4, -1);

        for (int f = 0; f < 8; f++) begin
            int w, h;
            w = $urandom_range(1, 12);
            h = $urandom_range(1, 8);
            clear_map();
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++)
                    skin_map[r][c] = ($urandom_range(0, 3) == 0);
            send_frame($sformatf("frand%0d", f), w, h, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
